// File: rtl/hit_pkg.sv
// Shared types and constants for the per-player hit/knockout controller.
// Contents: state enum, hit-animation damage bucket thresholds, the
// anim_id bit positions, and a helper that maps hit damage to a bucket.
package hit_pkg;

  typedef enum logic [2:0] {
    ST_ALIVE,
    ST_HITSTUN,
    ST_RESPAWN,
    ST_INVULN,
    ST_GAME_OVER
  } hit_state_t;

  localparam int ANIM_THR0      = 4;
  localparam int ANIM_THR1      = 10;
  localparam int ANIM_THR2      = 20;
  localparam int ANIM_AIR_BIT   = 3;
  localparam int ANIM_COMBO_BIT = 2;

  function automatic logic [1:0] anim_bucket(input logic [5:0] dmg);
    if (dmg < 6'(ANIM_THR0))      return 2'd0;
    else if (dmg < 6'(ANIM_THR1)) return 2'd1;
    else if (dmg < 6'(ANIM_THR2)) return 2'd2;
    else                          return 2'd3;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Frame-counted down-counter used for the hitstun and respawn/invuln timers.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_load          load i_load_val (takes priority; a tick in this cycle is not counted)
//   i_load_val      frame count N; the timer expires on the Nth tick after loading
//   i_frame_tick    one-cycle frame pulse
//   o_expire        tick arriving while count <= 1 (combinational, the owner gates it by state)
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_frame_tick,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_count <= '0;
    else if (i_load)                           r_count <= i_load_val;
    else if (i_frame_tick && r_count > W'(1))  r_count <= r_count - 1'b1;
  end

  assign o_expire = i_frame_tick && (r_count <= W'(1));

endmodule

// File: rtl/player_hit_fsm.sv
// Per-player damage / hitstun / knockout / respawn controller.
// Ports (all outputs registered):
//   i_clk, i_rst_n       clock, async active-low reset
//   i_frame_tick         one-cycle frame pulse
//   i_restart            synchronous round restart
//   i_got_hit            one-cycle hit event, i_hit_damage_in its damage
//   i_offscreen          player beyond blast zone (level)
//   i_grounded           player on stage
//   o_hit_stun_active    in HITSTUN
//   o_invincible         in RESPAWN or INVULN
//   o_can_grab_ledge     in ALIVE
//   o_hit_anim_id        {airborne, combo, damage bucket}
//   o_damage, o_stocks   percent damage, lives left
//   o_ko_pulse           one cycle per knockout
//   o_game_over          in GAME_OVER
//
// state      | meaning
// ALIVE      | normal play, hittable, can grab ledge
// HITSTUN    | stunned after a hit, stun timer running
// RESPAWN    | after KO, invincible, respawn timer running
// INVULN     | respawned, invincible, invuln timer running
// GAME_OVER  | no stocks left, sticky until restart
module player_hit_fsm
  import hit_pkg::*;
#(
  parameter int START_STOCKS   = 3,
  parameter int STOCK_W        = 2,
  parameter int DMG_W          = 10,
  parameter int MAX_DAMAGE     = 999,
  parameter int BASE_STUN      = 10,
  parameter int STUN_SHIFT     = 3,
  parameter int STUN_W         = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int TIMER_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_tick,
  input  logic               i_restart,
  input  logic               i_got_hit,
  input  logic [5:0]         i_hit_damage_in,
  input  logic               i_offscreen,
  input  logic               i_grounded,
  output logic               o_hit_stun_active,
  output logic               o_invincible,
  output logic               o_can_grab_ledge,
  output logic [3:0]         o_hit_anim_id,
  output logic [DMG_W-1:0]   o_damage,
  output logic [STOCK_W-1:0] o_stocks,
  output logic               o_ko_pulse,
  output logic               o_game_over
);

  localparam int SUM_W    = DMG_W + 1;
  localparam int STN_W    = DMG_W + STUN_W;
  localparam int STUN_MAX = (2 ** STUN_W) - 1;

  hit_state_t         r_state, w_state_nxt;
  logic [DMG_W-1:0]   r_damage, w_damage_nxt;
  logic [STOCK_W-1:0] r_stocks, w_stocks_nxt;
  logic [3:0]         r_anim, w_anim_nxt;
  logic               r_ko, r_stun_act, r_inv, r_ledge, r_go;
  logic               w_ko, w_stun_load, w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_val;
  logic               w_stun_exp, w_tmr_exp;

  logic [SUM_W-1:0]   w_sum;
  logic [DMG_W-1:0]   w_new_dmg;
  logic [STN_W-1:0]   w_stun_raw;
  logic [STUN_W-1:0]  w_stun;

  // Damage and stun are computed wide, then saturated.
  assign w_sum      = {1'b0, r_damage} + SUM_W'(i_hit_damage_in);
  assign w_new_dmg  = (w_sum > SUM_W'(MAX_DAMAGE)) ? DMG_W'(MAX_DAMAGE) : w_sum[DMG_W-1:0];
  assign w_stun_raw = STN_W'(BASE_STUN) + STN_W'(w_new_dmg >> STUN_SHIFT);
  assign w_stun     = (w_stun_raw > STN_W'(STUN_MAX)) ? '1 : w_stun_raw[STUN_W-1:0];

  frame_down_counter #(.W(STUN_W)) u_stun_tmr (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_stun_load),
    .i_load_val   (w_stun),
    .i_frame_tick (i_frame_tick),
    .o_expire     (w_stun_exp)
  );

  frame_down_counter #(.W(TIMER_W)) u_life_tmr (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_tmr_load),
    .i_load_val   (w_tmr_val),
    .i_frame_tick (i_frame_tick),
    .o_expire     (w_tmr_exp)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_damage_nxt = r_damage;
    w_stocks_nxt = r_stocks;
    w_anim_nxt   = r_anim;
    w_ko         = 1'b0;
    w_stun_load  = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = TIMER_W'(RESPAWN_FRAMES);
    if (i_restart) begin
      w_state_nxt  = ST_ALIVE;
      w_damage_nxt = '0;
      w_stocks_nxt = STOCK_W'(START_STOCKS);
      w_anim_nxt   = '0;
    end else begin
      case (r_state)
        ST_ALIVE, ST_HITSTUN: begin
          if (i_offscreen) begin
            w_ko         = 1'b1;
            w_damage_nxt = '0;
            w_anim_nxt   = '0;
            if (r_stocks == STOCK_W'(1)) begin
              w_stocks_nxt = '0;
              w_state_nxt  = ST_GAME_OVER;
            end else begin
              w_stocks_nxt = r_stocks - 1'b1;
              w_state_nxt  = ST_RESPAWN;
              w_tmr_load   = 1'b1;
            end
          end else if (i_got_hit) begin
            w_damage_nxt = w_new_dmg;
            w_anim_nxt   = {~i_grounded, (r_state == ST_HITSTUN), anim_bucket(i_hit_damage_in)};
            w_state_nxt  = ST_HITSTUN;
            w_stun_load  = 1'b1;
          end else if (r_state == ST_HITSTUN && w_stun_exp) begin
            w_state_nxt = ST_ALIVE;
            w_anim_nxt  = '0;
          end
        end
        ST_RESPAWN: begin
          if (w_tmr_exp) begin
            w_state_nxt = ST_INVULN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TIMER_W'(INVULN_FRAMES);
          end
        end
        ST_INVULN: begin
          if (w_tmr_exp) w_state_nxt = ST_ALIVE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_ALIVE;
      r_damage   <= '0;
      r_stocks   <= STOCK_W'(START_STOCKS);
      r_anim     <= '0;
      r_ko       <= 1'b0;
      r_stun_act <= 1'b0;
      r_inv      <= 1'b0;
      r_ledge    <= 1'b1;
      r_go       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_damage   <= w_damage_nxt;
      r_stocks   <= w_stocks_nxt;
      r_anim     <= w_anim_nxt;
      r_ko       <= w_ko;
      r_stun_act <= (w_state_nxt == ST_HITSTUN);
      r_inv      <= (w_state_nxt == ST_RESPAWN) || (w_state_nxt == ST_INVULN);
      r_ledge    <= (w_state_nxt == ST_ALIVE);
      r_go       <= (w_state_nxt == ST_GAME_OVER);
    end
  end

  assign o_hit_stun_active = r_stun_act;
  assign o_invincible      = r_inv;
  assign o_can_grab_ledge  = r_ledge;
  assign o_hit_anim_id     = r_anim;
  assign o_damage          = r_damage;
  assign o_stocks          = r_stocks;
  assign o_ko_pulse        = r_ko;
  assign o_game_over       = r_go;

endmodule

// File: tb/tb_player_hit_fsm.sv
// Directed bench for player_hit_fsm with default parameters.
module tb_player_hit_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, restart, got_hit, offscreen, grounded;
  logic [5:0] hit_dmg;
  logic       stun_act, inv, ledge, ko, go;
  logic [3:0] anim;
  logic [9:0] damage;
  logic [1:0] stocks;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  player_hit_fsm dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_frame_tick      (frame_tick),
    .i_restart         (restart),
    .i_got_hit         (got_hit),
    .i_hit_damage_in   (hit_dmg),
    .i_offscreen       (offscreen),
    .i_grounded        (grounded),
    .o_hit_stun_active (stun_act),
    .o_invincible      (inv),
    .o_can_grab_ledge  (ledge),
    .o_hit_anim_id     (anim),
    .o_damage          (damage),
    .o_stocks          (stocks),
    .o_ko_pulse        (ko),
    .o_game_over       (go)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
  endtask

  task automatic hit(input logic [5:0] d, input logic gnd, input logic ft);
    got_hit = 1'b1; hit_dmg = d; grounded = gnd; frame_tick = ft;
    step();
    got_hit = 1'b0; frame_tick = 1'b0; grounded = 1'b1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 0; restart = 0; got_hit = 0;
    offscreen = 0; grounded = 1; hit_dmg = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_damage", 32'(damage), 0);
    chk("rst_stocks", 32'(stocks), 3);
    chk("rst_anim", 32'(anim), 0);
    chk("rst_stun", 32'(stun_act), 0);
    chk("rst_inv", 32'(inv), 0);
    chk("rst_ledge", 32'(ledge), 1);
    chk("rst_ko", 32'(ko), 0);
    chk("rst_go", 32'(go), 0);

    // grounded hit 12: stun 10 + 12>>3 = 11 frames
    hit(6'd12, 1'b1, 1'b0);
    chk("h12_damage", 32'(damage), 12);
    chk("h12_stun", 32'(stun_act), 1);
    chk("h12_anim", 32'(anim), 4'b0010);
    chk("h12_ledge", 32'(ledge), 0);
    ticks(10);
    chk("h12_stun_t10", 32'(stun_act), 1);
    ticks(1);
    chk("h12_stun_t11", 32'(stun_act), 0);
    chk("h12_ledge_end", 32'(ledge), 1);
    chk("h12_anim_end", 32'(anim), 0);

    // combo: airborne 25 after 5 ticks, with a tick in the load cycle (ignored)
    do_restart();
    chk("rs_damage", 32'(damage), 0);
    hit(6'd12, 1'b1, 1'b0);
    ticks(5);
    hit(6'd25, 1'b0, 1'b1);
    chk("combo_damage", 32'(damage), 37);
    chk("combo_anim", 32'(anim), 4'b1111);
    ticks(13);
    chk("combo_stun_t13", 32'(stun_act), 1);
    ticks(1);
    chk("combo_stun_t14", 32'(stun_act), 0);

    // saturation: 15*63 + 45 = 990, +30 -> 999, stun 10+124 = 134
    do_restart();
    for (int i = 0; i < 15; i++) hit(6'd63, 1'b1, 1'b0);
    chk("acc_945", 32'(damage), 945);
    hit(6'd45, 1'b1, 1'b0);
    chk("acc_990", 32'(damage), 990);
    hit(6'd30, 1'b0, 1'b0);
    chk("sat_999", 32'(damage), 999);
    chk("sat_anim", 32'(anim), 4'b1111);
    ticks(133);
    chk("sat_stun_t133", 32'(stun_act), 1);
    ticks(1);
    chk("sat_stun_t134", 32'(stun_act), 0);
    hit(6'd63, 1'b1, 1'b0);
    chk("sat_hold", 32'(damage), 999);
    chk("sat_anim2", 32'(anim), 4'b0011);

    // anim bucket boundaries
    do_restart();
    hit(6'd3, 1'b1, 1'b0);  chk("bkt_3", 32'(anim), 4'b0000);
    hit(6'd4, 1'b1, 1'b0);  chk("bkt_4", 32'(anim), 4'b0101);
    hit(6'd9, 1'b1, 1'b0);  chk("bkt_9", 32'(anim), 4'b0101);
    hit(6'd10, 1'b1, 1'b0); chk("bkt_10", 32'(anim), 4'b0110);
    hit(6'd19, 1'b1, 1'b0); chk("bkt_19", 32'(anim), 4'b0110);
    hit(6'd20, 1'b1, 1'b0); chk("bkt_20", 32'(anim), 4'b0111);
    chk("bkt_damage", 32'(damage), 65);

    // KO from HITSTUN with offscreen held two cycles
    offscreen = 1'b1;
    step();
    chk("ko1_pulse", 32'(ko), 1);
    chk("ko1_stocks", 32'(stocks), 2);
    chk("ko1_damage", 32'(damage), 0);
    chk("ko1_inv", 32'(inv), 1);
    chk("ko1_stun", 32'(stun_act), 0);
    chk("ko1_anim", 32'(anim), 0);
    chk("ko1_ledge", 32'(ledge), 0);
    step();
    chk("ko1_pulse_once", 32'(ko), 0);
    chk("ko1_stocks_hold", 32'(stocks), 2);
    offscreen = 1'b0;
    hit(6'd10, 1'b1, 1'b0);
    chk("inv_hit_dmg", 32'(damage), 0);
    chk("inv_hit_stun", 32'(stun_act), 0);
    ticks(179);
    chk("inv_t179", 32'(inv), 1);
    ticks(1);
    chk("inv_t180", 32'(inv), 0);
    chk("inv_end_ledge", 32'(ledge), 1);

    // KO to 1 stock, then to game over
    offscreen = 1'b1; step(); offscreen = 1'b0;
    chk("ko2_stocks", 32'(stocks), 1);
    ticks(180);
    chk("ko2_alive", 32'(ledge), 1);
    offscreen = 1'b1; step(); offscreen = 1'b0;
    chk("ko3_pulse", 32'(ko), 1);
    chk("ko3_stocks", 32'(stocks), 0);
    chk("ko3_go", 32'(go), 1);
    chk("ko3_inv", 32'(inv), 0);
    step();
    chk("ko3_pulse_once", 32'(ko), 0);
    hit(6'd20, 1'b1, 1'b0);
    chk("go_hit_dmg", 32'(damage), 0);
    chk("go_hit_stun", 32'(stun_act), 0);
    offscreen = 1'b1; step(); offscreen = 1'b0;
    chk("go_off_ko", 32'(ko), 0);
    chk("go_sticky", 32'(go), 1);
    do_restart();
    chk("rs_stocks", 32'(stocks), 3);
    chk("rs_go", 32'(go), 0);
    chk("rs_ledge", 32'(ledge), 1);

    // got_hit and offscreen together: KO wins
    hit(6'd5, 1'b1, 1'b0);
    chk("pre_both_dmg", 32'(damage), 5);
    got_hit = 1'b1; hit_dmg = 6'd30; offscreen = 1'b1;
    step();
    got_hit = 1'b0; offscreen = 1'b0;
    chk("both_ko", 32'(ko), 1);
    chk("both_dmg", 32'(damage), 0);
    chk("both_stun", 32'(stun_act), 0);
    chk("both_stocks", 32'(stocks), 2);

    // reset mid-respawn aborts at once
    ticks(30);
    rst_n = 1'b0;
    #1;
    chk("rstmid_inv", 32'(inv), 0);
    chk("rstmid_stocks", 32'(stocks), 3);
    chk("rstmid_ledge", 32'(ledge), 1);
    step();
    rst_n = 1'b1;
    ticks(40);
    chk("rstmid_ko", 32'(ko), 0);
    chk("rstmid_inv2", 32'(inv), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
